hyperbus_phy_seq: RTL and testbench
===================================

HYPERBUS_PHY_SEQ -- requirements
Module: hyperbus_phy_seq

Interface
REQ-001 SHALL have parameter NumChips, default 2 (>=2), number of chip selects.
REQ-002 SHALL have parameter BurstWidth, default 8, width of burst-length field (words minus one).
REQ-003 SHALL have parameter LatencyCycles, default 6, initial access latency in clk_i cycles.
REQ-004 SHALL have parameter CsRecoveryCycles, default 2, CS-high cycles between transactions.
REQ-005 SHALL have parameter TimeoutCycles, default 1024, read inactivity limit.
REQ-006 One clock; reset is synchronous and active-high: clk_i in 1 system/PHY clock; rst_i in 1 synchronous active-high reset.
REQ-007 SHALL have request ports:
- req_valid_i in 1
- req_ready_o out 1
- req_write_i in 1 (1=write)
- req_addr_i in 32 (16-bit word address)
- req_cs_i in $clog2(NumChips)
- req_len_i in BurstWidth (words-1)
REQ-008 SHALL have write-data ports: wdata_i in 16; wstrb_i in 2 (bit1=upper byte); wvalid_i in 1; wready_o out 1.
REQ-009 SHALL have read and status ports: rdata_o out 16; rvalid_o out 1; rready_i in 1; done_o out 1 (pulse); error_o out 1 (pulse).
REQ-010 SHALL have transceiver-facing ports:
- trx_cs_o out NumChips
- trx_cs_ena_o out 1
- trx_rwds_sample_ena_o out 1
- trx_rwds_sample_i in 1
- trx_tx_clk_ena_o out 1
- trx_tx_data_o out 16
- trx_tx_data_oe_o out 1
- trx_tx_rwds_o out 2
- trx_tx_rwds_oe_o out 1
- trx_rx_clk_set_o out 1
- trx_rx_clk_reset_o out 1
- trx_rx_data_i in 16
- trx_rx_valid_i in 1
- trx_rx_ready_o out 1

Function
REQ-011 SHALL implement states IDLE, CS_SETUP, CA, LATENCY, WRITE, READ, CS_HOLD, RECOVERY.
REQ-012 SHALL handle IDLE as follows:
- req_ready_o=1 only in IDLE.
- On req_valid_i&req_ready_o, latch write, addr, cs, len; go to CS_SETUP.
REQ-013 SHALL drive trx_cs_o one-hot of latched cs; trx_cs_ena_o=1 in CS_SETUP, CA, LATENCY, WRITE, READ, CS_HOLD, else 0.
REQ-014 CS_SETUP SHALL last 1 cycle, all clock and oe outputs 0, and go to CA.
REQ-015 CA SHALL last 3 cycles with tx_clk_ena=1 and data_oe=1, and go to LATENCY.
- trx_tx_data_o = CA[47:32], CA[31:16], CA[15:0] in those cycles.
- CA[47]=~write; CA[46]=0; CA[45]=1; CA[44:16]=addr[31:3]; CA[15:3]=0; CA[2:0]=addr[2:0].
REQ-016 SHALL assert trx_rwds_sample_ena_o in CA cycle 1 only, and latch trx_rwds_sample_i in CA cycle 2 as the extra-latency flag.
REQ-017 LATENCY SHALL have tx_clk_ena=1 and oe=0.
- Lasts LatencyCycles cycles if flag=0, 2*LatencyCycles if flag=1.
- Then go to WRITE or READ.
REQ-018 WRITE SHALL have tx_clk_ena=1, data_oe=1, rwds_oe=1 and transfer exactly len+1 words, one per cycle.
- wready_o=1 when in WRITE and wvalid_i=1.
- Handshake: data=wdata_i, rwds=~wstrb_i.
- wvalid_i=0: data=0, rwds=2'b11 (masked word), still counted.
REQ-019 SHALL assert trx_rx_clk_set_o for exactly the first READ cycle.
- tx_clk_ena=1 for exactly len+1 READ cycles, then 0.
- rdata_o=trx_rx_data_i, rvalid_o=trx_rx_valid_i, trx_rx_ready_o=rready_i (combinational).
- Count rvalid_o&rready_i; when count reaches len+1, pulse trx_rx_clk_reset_o and go to CS_HOLD.
REQ-020 CS_HOLD SHALL last 1 cycle, all clock and oe outputs 0, then go to RECOVERY.
REQ-021 RECOVERY SHALL last CsRecoveryCycles cycles with cs_ena=0, then go to IDLE with a done_o pulse in the final RECOVERY cycle.
REQ-022 SHALL size word counters to BurstWidth+1 bits so len=all-ones (2^BurstWidth words) does not wrap.
REQ-023 SHALL ignore req_valid_i outside IDLE; wready_o=0 outside WRITE.

Reset
REQ-024 When rst_i=1 at a clk_i edge, state SHALL become IDLE and all outputs 0, including mid-transaction.
- Exceptions: req_ready_o=1, trx_rx_ready_o=rready_i.
- All counters and latched flags cleared.

Configuration
REQ-025 With HYPERBUS_PHY_SEQ_TIMEOUT_EN defined, READ SHALL count cycles since entry or last received word.
- On reaching TimeoutCycles: pulse error_o and trx_rx_clk_reset_o, go to CS_HOLD.
- Normal done_o follows.
REQ-026 Without HYPERBUS_PHY_SEQ_TIMEOUT_EN, there SHALL be no timeout counter, error_o tied 0, and READ waits indefinitely.

Verification
REQ-027 Write, len=3, addr=0x100, flag=0, wvalid always 1 -> CA words 0x2000/0x0020/0x0000, 6 latency cycles, 4 data words, done_o after 2 recovery cycles.
REQ-028 Read, len=1, trx_rwds_sample_i=1 during sample -> LATENCY 12 cycles, rx_clk_set 1 cycle, tx_clk_ena 2 cycles, 2 words delivered, rx_clk_reset pulse.
REQ-029 Write, len=3, wvalid_i low in word 2 -> that word data=0x0000, rwds=2'b11; wstrb_i=2'b01 word -> rwds=2'b10.
REQ-030 Read, rx_valid never arrives, macro defined, TimeoutCycles=16 -> error_o after 16 cycles, then done_o; macro undefined -> stays in READ.
REQ-031 rst_i asserted in WRITE word 1 -> next cycle cs_ena=0, oe=0, req_ready_o=1; a new request then completes normally.
REQ-032 req_len_i=255, BurstWidth=8 -> exactly 256 words, no counter wrap.

Source files
------------

// File: rtl/hyperbus_phy_seq.sv
// HyperBus PHY transaction sequencer: CS/CA/latency/data framing toward the transceiver.
// Optional read inactivity timeout enabled by defining HYPERBUS_PHY_SEQ_TIMEOUT_EN.
module hyperbus_phy_seq #(
    parameter int NumChips         = 2,
    parameter int BurstWidth       = 8,
    parameter int LatencyCycles    = 6,
    parameter int CsRecoveryCycles = 2,
    parameter int TimeoutCycles    = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_write_i,
    input  logic [31:0]                 req_addr_i,
    input  logic [$clog2(NumChips)-1:0] req_cs_i,
    input  logic [BurstWidth-1:0]       req_len_i,
    input  logic [15:0]                 wdata_i,
    input  logic [1:0]                  wstrb_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    output logic [15:0]                 rdata_o,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic                        done_o,
    output logic                        error_o,
    output logic [NumChips-1:0]         trx_cs_o,
    output logic                        trx_cs_ena_o,
    output logic                        trx_rwds_sample_ena_o,
    input  logic                        trx_rwds_sample_i,
    output logic                        trx_tx_clk_ena_o,
    output logic [15:0]                 trx_tx_data_o,
    output logic                        trx_tx_data_oe_o,
    output logic [1:0]                  trx_tx_rwds_o,
    output logic                        trx_tx_rwds_oe_o,
    output logic                        trx_rx_clk_set_o,
    output logic                        trx_rx_clk_reset_o,
    input  logic [15:0]                 trx_rx_data_i,
    input  logic                        trx_rx_valid_i,
    output logic                        trx_rx_ready_o
);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, CA, LATENCY, WRITE, READ, CS_HOLD, RECOVERY
    } state_e;

    localparam int CycW = $clog2(2*LatencyCycles + CsRecoveryCycles + 4);

    state_e                      state_q, state_d;
    logic                        write_q, flag_q;
    logic [31:0]                 addr_q;
    logic [$clog2(NumChips)-1:0] cs_q;
    logic [BurstWidth-1:0]       len_q;
    logic [CycW-1:0]             cyc_q;
    // One extra bit so a full 2^BurstWidth burst never wraps.
    logic [BurstWidth:0]         wcnt_q, rclk_q, len_ext;
    logic [47:0]                 ca;
    logic                        lat_last, rx_fire, rd_last, to_hit;

    assign len_ext  = {1'b0, len_q};
    assign ca       = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};
    assign lat_last = cyc_q == (flag_q ? CycW'(2*LatencyCycles - 1) : CycW'(LatencyCycles - 1));
    assign rvalid_o = (state_q == READ) & trx_rx_valid_i;
    assign rdata_o  = (state_q == READ) ? trx_rx_data_i : 16'h0000;
    assign rx_fire  = rvalid_o & rready_i;
    assign rd_last  = rx_fire && (wcnt_q == len_ext);
    assign trx_rx_ready_o = rready_i;
    assign trx_cs_o = trx_cs_ena_o ? (NumChips'(1) << cs_q) : '0;

`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
    localparam int ToW = $clog2(TimeoutCycles + 1);
    logic [ToW-1:0] tcnt_q;

    // Restarts on READ entry and on every accepted word.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                tcnt_q <= '0;
        else if (state_d != state_q || rx_fire)   tcnt_q <= '0;
        else if (state_q == READ)                 tcnt_q <= tcnt_q + 1'b1;
    end
    assign to_hit = (state_q == READ) && !rx_fire && (tcnt_q == ToW'(TimeoutCycles - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (req_valid_i) state_d = CS_SETUP;
            CS_SETUP: state_d = CA;
            CA:       if (cyc_q == CycW'(2)) state_d = LATENCY;
            LATENCY:  if (lat_last) state_d = write_q ? WRITE : READ;
            WRITE:    if (wcnt_q == len_ext) state_d = CS_HOLD;
            READ:     if (rd_last || to_hit) state_d = CS_HOLD;
            CS_HOLD:  state_d = RECOVERY;
            RECOVERY: if (cyc_q == CycW'(CsRecoveryCycles - 1)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            cs_q    <= '0;
            len_q   <= '0;
            flag_q  <= 1'b0;
            cyc_q   <= '0;
            wcnt_q  <= '0;
            rclk_q  <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                cs_q    <= req_cs_i;
                len_q   <= req_len_i;
            end
            if (state_q == CA && cyc_q == CycW'(2)) flag_q <= trx_rwds_sample_i;
            cyc_q <= (state_d != state_q) ? '0 : cyc_q + 1'b1;
            if (state_d != state_q)                   wcnt_q <= '0;
            else if (state_q == WRITE || rx_fire)     wcnt_q <= wcnt_q + 1'b1;
            if (state_d != state_q)                         rclk_q <= '0;
            else if (state_q == READ && rclk_q <= len_ext)  rclk_q <= rclk_q + 1'b1;
        end
    end

    always_comb begin
        req_ready_o           = 1'b0;
        wready_o              = 1'b0;
        done_o                = 1'b0;
        error_o               = 1'b0;
        trx_cs_ena_o          = 1'b0;
        trx_rwds_sample_ena_o = 1'b0;
        trx_tx_clk_ena_o      = 1'b0;
        trx_tx_data_o         = 16'h0000;
        trx_tx_data_oe_o      = 1'b0;
        trx_tx_rwds_o         = 2'b00;
        trx_tx_rwds_oe_o      = 1'b0;
        trx_rx_clk_set_o      = 1'b0;
        trx_rx_clk_reset_o    = 1'b0;
        unique case (state_q)
            IDLE:     req_ready_o = 1'b1;
            CS_SETUP: trx_cs_ena_o = 1'b1;
            CA: begin
                trx_cs_ena_o          = 1'b1;
                trx_tx_clk_ena_o      = 1'b1;
                trx_tx_data_oe_o      = 1'b1;
                trx_rwds_sample_ena_o = (cyc_q == CycW'(1));
                trx_tx_data_o = (cyc_q == '0)         ? ca[47:32] :
                                (cyc_q == CycW'(1))   ? ca[31:16] : ca[15:0];
            end
            LATENCY: begin
                trx_cs_ena_o     = 1'b1;
                trx_tx_clk_ena_o = 1'b1;
            end
            WRITE: begin
                trx_cs_ena_o     = 1'b1;
                trx_tx_clk_ena_o = 1'b1;
                trx_tx_data_oe_o = 1'b1;
                trx_tx_rwds_oe_o = 1'b1;
                wready_o         = wvalid_i;
                // A missing beat still goes out, fully masked.
                trx_tx_data_o    = wvalid_i ? wdata_i : 16'h0000;
                trx_tx_rwds_o    = wvalid_i ? ~wstrb_i : 2'b11;
            end
            READ: begin
                trx_cs_ena_o       = 1'b1;
                trx_tx_clk_ena_o   = (rclk_q <= len_ext);
                trx_rx_clk_set_o   = (rclk_q == '0);
                trx_rx_clk_reset_o = rd_last | to_hit;
                error_o            = to_hit;
            end
            CS_HOLD:  trx_cs_ena_o = 1'b1;
            RECOVERY: done_o = (cyc_q == CycW'(CsRecoveryCycles - 1));
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hyperbus_phy_seq.sv
// Directed self-checking bench for hyperbus_phy_seq (default parameters, TimeoutCycles=16).
module tb_hyperbus_phy_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i;
    logic [0:0]  req_cs_i;
    logic [7:0]  req_len_i;
    logic [15:0] wdata_i;
    logic [1:0]  wstrb_i;
    logic        wvalid_i, wready_o;
    logic [15:0] rdata_o;
    logic        rvalid_o, rready_i, done_o, error_o;
    logic [1:0]  trx_cs_o;
    logic        trx_cs_ena_o, trx_rwds_sample_ena_o, trx_rwds_sample_i;
    logic        trx_tx_clk_ena_o;
    logic [15:0] trx_tx_data_o;
    logic        trx_tx_data_oe_o;
    logic [1:0]  trx_tx_rwds_o;
    logic        trx_tx_rwds_oe_o, trx_rx_clk_set_o, trx_rx_clk_reset_o;
    logic [15:0] trx_rx_data_i;
    logic        trx_rx_valid_i, trx_rx_ready_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hyperbus_phy_seq #(.TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_cs_i(req_cs_i), .req_len_i(req_len_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .done_o(done_o), .error_o(error_o),
        .trx_cs_o(trx_cs_o), .trx_cs_ena_o(trx_cs_ena_o),
        .trx_rwds_sample_ena_o(trx_rwds_sample_ena_o), .trx_rwds_sample_i(trx_rwds_sample_i),
        .trx_tx_clk_ena_o(trx_tx_clk_ena_o), .trx_tx_data_o(trx_tx_data_o),
        .trx_tx_data_oe_o(trx_tx_data_oe_o), .trx_tx_rwds_o(trx_tx_rwds_o),
        .trx_tx_rwds_oe_o(trx_tx_rwds_oe_o), .trx_rx_clk_set_o(trx_rx_clk_set_o),
        .trx_rx_clk_reset_o(trx_rx_clk_reset_o), .trx_rx_data_i(trx_rx_data_i),
        .trx_rx_valid_i(trx_rx_valid_i), .trx_rx_ready_o(trx_rx_ready_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic cs, input logic [7:0] len);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_cs_i = cs; req_len_i = len;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_write_data;
        int g = 0;
        while (trx_tx_rwds_oe_o !== 1'b1 && g < 60) begin tick(); g++; end
        checks++;
        if (g >= 60) begin errors++; $display("FAIL wait_write_data timed out after %0d cycles", g); end
    endtask

    task automatic wait_done;
        int g = 0;
        while (done_o !== 1'b1 && g < 60) begin tick(); g++; end
        checks++;
        if (g >= 60) begin errors++; $display("FAIL wait_done timed out after %0d cycles", g); end
        tick();
    endtask

    task automatic test_reset;
        rst_i = 1'b1; rready_i = 1'b1;
        tick(); tick();
        checks++;
        if ({req_ready_o, trx_cs_ena_o, trx_cs_o, trx_tx_clk_ena_o, done_o, error_o} !== 7'b1000000) begin
            errors++; $display("FAIL reset_outputs got %b want 1000000",
                {req_ready_o, trx_cs_ena_o, trx_cs_o, trx_tx_clk_ena_o, done_o, error_o});
        end
        checks++;
        if (trx_rx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rx_ready_hi got %b want 1", trx_rx_ready_o); end
        rready_i = 1'b0; #1;
        checks++;
        if (trx_rx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rx_ready_lo got %b want 0", trx_rx_ready_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_write_basic;
        logic [15:0] ca_exp [3];
        int n = 0, g = 0;
        ca_exp = '{16'h2000, 16'h0020, 16'h0000};
        wvalid_i = 1'b1; wstrb_i = 2'b11;
        issue(1'b1, 32'h0000_0100, 1'b1, 8'd3);
        checks++;
        if ({trx_cs_ena_o, trx_cs_o, trx_tx_clk_ena_o, trx_tx_data_oe_o, req_ready_o} !== 6'b110000) begin
            errors++; $display("FAIL wr_cs_setup got %b want 110000",
                {trx_cs_ena_o, trx_cs_o, trx_tx_clk_ena_o, trx_tx_data_oe_o, req_ready_o});
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({trx_tx_data_o, trx_tx_clk_ena_o, trx_tx_data_oe_o, trx_rwds_sample_ena_o} !==
                {ca_exp[i], 1'b1, 1'b1, (i == 1)}) begin
                errors++; $display("FAIL wr_ca%0d got %h/%b%b%b want %h/11%0d", i, trx_tx_data_o,
                    trx_tx_clk_ena_o, trx_tx_data_oe_o, trx_rwds_sample_ena_o, ca_exp[i], (i == 1));
            end
            tick();
        end
        while (trx_tx_rwds_oe_o !== 1'b1 && g < 60) begin
            if (trx_tx_clk_ena_o === 1'b1 && trx_tx_data_oe_o === 1'b0) n++;
            tick(); g++;
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL wr_latency got %0d want 6", n); end
        for (int w = 0; w < 4; w++) begin
            wdata_i = 16'hA000 + 16'(w); #1;
            checks++;
            if ({trx_tx_data_o, trx_tx_rwds_o, wready_o, trx_tx_data_oe_o} !== {16'hA000 + 16'(w), 2'b00, 2'b11}) begin
                errors++; $display("FAIL wr_word%0d got %h/%b/%b want %h/00/1", w,
                    trx_tx_data_o, trx_tx_rwds_o, wready_o, 16'hA000 + 16'(w));
            end
            tick();
        end
        checks++;
        if ({trx_cs_ena_o, trx_tx_clk_ena_o, trx_tx_data_oe_o, trx_tx_rwds_oe_o, done_o} !== 5'b10000) begin
            errors++; $display("FAIL wr_cs_hold got %b want 10000",
                {trx_cs_ena_o, trx_tx_clk_ena_o, trx_tx_data_oe_o, trx_tx_rwds_oe_o, done_o});
        end
        tick();
        checks++;
        if ({trx_cs_ena_o, done_o} !== 2'b00) begin errors++; $display("FAIL wr_recovery0 got %b want 00", {trx_cs_ena_o, done_o}); end
        tick();
        checks++;
        if ({trx_cs_ena_o, done_o, req_ready_o} !== 3'b010) begin errors++; $display("FAIL wr_done got %b want 010", {trx_cs_ena_o, done_o, req_ready_o}); end
        tick();
        checks++;
        if ({req_ready_o, done_o} !== 2'b10) begin errors++; $display("FAIL wr_idle got %b want 10", {req_ready_o, done_o}); end
        wvalid_i = 1'b0;
    endtask

    task automatic test_write_mask;
        logic [15:0] d_in  [4];
        logic [1:0]  s_in  [4];
        logic        v_in  [4];
        logic [15:0] d_exp [4];
        logic [1:0]  r_exp [4];
        d_in = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        s_in = '{2'b11, 2'b01, 2'b11, 2'b10};
        v_in = '{1'b1, 1'b1, 1'b0, 1'b1};
        d_exp = '{16'h1111, 16'h2222, 16'h0000, 16'h4444};
        r_exp = '{2'b00, 2'b10, 2'b11, 2'b01};
        issue(1'b1, 32'h2000_0007, 1'b0, 8'd3);
        wait_write_data();
        for (int w = 0; w < 4; w++) begin
            wdata_i = d_in[w]; wstrb_i = s_in[w]; wvalid_i = v_in[w]; #1;
            checks++;
            if ({trx_tx_data_o, trx_tx_rwds_o, wready_o, trx_cs_o} !== {d_exp[w], r_exp[w], v_in[w], 2'b01}) begin
                errors++; $display("FAIL mask_word%0d got %h/%b/%b/%b want %h/%b/%b/01", w, trx_tx_data_o,
                    trx_tx_rwds_o, wready_o, trx_cs_o, d_exp[w], r_exp[w], v_in[w]);
            end
            tick();
        end
        wvalid_i = 1'b0;
        checks++;
        if ({trx_cs_ena_o, trx_tx_rwds_oe_o, wready_o} !== 3'b100) begin
            errors++; $display("FAIL mask_end got %b want 100", {trx_cs_ena_o, trx_tx_rwds_oe_o, wready_o});
        end
        wait_done();
    endtask

    task automatic test_read_flag;
        logic [15:0] ca_exp [3];
        int n = 0, g = 0, nclk = 0, nw = 0;
        ca_exp = '{16'hA400, 16'h0000, 16'h0007};
        rready_i = 1'b1; trx_rx_valid_i = 1'b0; trx_rwds_sample_i = 1'b1;
        issue(1'b0, 32'h2000_0007, 1'b1, 8'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({trx_tx_data_o, trx_rwds_sample_ena_o} !== {ca_exp[i], (i == 1)}) begin
                errors++; $display("FAIL rd_ca%0d got %h/%b want %h/%0d", i, trx_tx_data_o,
                    trx_rwds_sample_ena_o, ca_exp[i], (i == 1));
            end
            tick();
        end
        trx_rwds_sample_i = 1'b0;
        while (trx_rx_clk_set_o !== 1'b1 && g < 60) begin
            if (trx_tx_clk_ena_o === 1'b1 && trx_tx_data_oe_o === 1'b0) n++;
            tick(); g++;
        end
        checks++;
        if (n != 12) begin errors++; $display("FAIL rd_latency got %0d want 12", n); end
        // READ cycle 0: no data yet
        if (trx_tx_clk_ena_o === 1'b1) nclk++;
        tick();
        checks++;
        if (trx_rx_clk_set_o !== 1'b0) begin errors++; $display("FAIL rd_clk_set_once got %b want 0", trx_rx_clk_set_o); end
        trx_rx_valid_i = 1'b1; trx_rx_data_i = 16'hAAAA; #1;
        if (rvalid_o === 1'b1 && rready_i === 1'b1) nw++;
        if (trx_tx_clk_ena_o === 1'b1) nclk++;
        checks++;
        if ({rvalid_o, rdata_o, trx_rx_clk_reset_o} !== {1'b1, 16'hAAAA, 1'b0}) begin
            errors++; $display("FAIL rd_word0 got %b/%h/%b want 1/aaaa/0", rvalid_o, rdata_o, trx_rx_clk_reset_o);
        end
        tick();
        trx_rx_data_i = 16'h5555; #1;
        if (rvalid_o === 1'b1 && rready_i === 1'b1) nw++;
        if (trx_tx_clk_ena_o === 1'b1) nclk++;
        checks++;
        if ({rvalid_o, rdata_o, trx_rx_clk_reset_o} !== {1'b1, 16'h5555, 1'b1}) begin
            errors++; $display("FAIL rd_word1 got %b/%h/%b want 1/5555/1", rvalid_o, rdata_o, trx_rx_clk_reset_o);
        end
        tick();
        trx_rx_valid_i = 1'b0;
        checks++;
        if (nclk != 2 || nw != 2) begin errors++; $display("FAIL rd_clk_words got clk=%0d words=%0d want 2/2", nclk, nw); end
        checks++;
        if ({trx_cs_ena_o, trx_tx_clk_ena_o, trx_rx_clk_reset_o, rvalid_o} !== 4'b1000) begin
            errors++; $display("FAIL rd_cs_hold got %b want 1000", {trx_cs_ena_o, trx_tx_clk_ena_o, trx_rx_clk_reset_o, rvalid_o});
        end
        wait_done();
    endtask

    task automatic test_timeout;
        int g = 0;
        rready_i = 1'b1; trx_rx_valid_i = 1'b0; trx_rwds_sample_i = 1'b0;
        issue(1'b0, 32'h0000_0040, 1'b0, 8'd0);
        while (trx_rx_clk_set_o !== 1'b1 && g < 60) begin tick(); g++; end
        checks++;
        if (g >= 60) begin errors++; $display("FAIL to_reach_read timed out after %0d cycles", g); end
`ifdef HYPERBUS_PHY_SEQ_TIMEOUT_EN
        g = 1;
        while (error_o !== 1'b1 && g < 40) begin tick(); g++; end
        checks++;
        if (g != 16 || trx_rx_clk_reset_o !== 1'b1) begin
            errors++; $display("FAIL to_error got cycle %0d rx_reset %b want 16/1", g, trx_rx_clk_reset_o);
        end
        tick(); tick(); tick();
        checks++;
        if ({done_o, error_o} !== 2'b10) begin errors++; $display("FAIL to_done got %b want 10", {done_o, error_o}); end
        tick();
`else
        repeat (40) tick();
        checks++;
        if ({trx_cs_ena_o, req_ready_o, error_o, done_o} !== 4'b1000) begin
            errors++; $display("FAIL to_stays_read got %b want 1000", {trx_cs_ena_o, req_ready_o, error_o, done_o});
        end
        rst_i = 1'b1; tick(); rst_i = 1'b0;
`endif
    endtask

    task automatic test_reset_mid;
        wvalid_i = 1'b1; wstrb_i = 2'b11; wdata_i = 16'hBEEF;
        issue(1'b1, 32'h0000_0300, 1'b1, 8'd3);
        wait_write_data();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({trx_cs_ena_o, trx_tx_data_oe_o, trx_tx_rwds_oe_o, trx_tx_clk_ena_o, req_ready_o, trx_cs_o, wready_o} !== 8'b00001000) begin
            errors++; $display("FAIL midrst_outputs got %b want 00001000",
                {trx_cs_ena_o, trx_tx_data_oe_o, trx_tx_rwds_oe_o, trx_tx_clk_ena_o, req_ready_o, trx_cs_o, wready_o});
        end
        issue(1'b1, 32'h0000_0300, 1'b1, 8'd0);
        wait_done();
        wvalid_i = 1'b0;
    endtask

    task automatic test_long_burst;
        int n = 0;
        wvalid_i = 1'b1; wstrb_i = 2'b00; wdata_i = 16'h0F0F;
        issue(1'b1, 32'h0000_0000, 1'b0, 8'd255);
        wait_write_data();
        while (trx_tx_rwds_oe_o === 1'b1 && n < 400) begin n++; tick(); end
        checks++;
        if (n != 256) begin errors++; $display("FAIL long_words got %0d want 256", n); end
        checks++;
        if ({trx_cs_ena_o, trx_tx_clk_ena_o} !== 2'b10) begin
            errors++; $display("FAIL long_cs_hold got %b want 10", {trx_cs_ena_o, trx_tx_clk_ena_o});
        end
        wait_done();
        wvalid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_cs_i = '0;
        req_len_i = '0; wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; rready_i = 1'b0;
        trx_rwds_sample_i = 1'b0; trx_rx_data_i = '0; trx_rx_valid_i = 1'b0;
        test_reset();
        test_write_basic();
        test_write_mask();
        test_read_flag();
        test_timeout();
        test_reset_mid();
        test_long_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
